router_op_lut_arp_table: RTL and testbench
==========================================

Name: router_op_lut_arp_table

Overview:
- Next-hop ARP table directly downstream of the op_lut register block.
- Consumes that block's arp_rd_*/arp_wr_* table-access port and stores DEPTH (IP, MAC) pairs in flops.
- Serves sequential-scan lookups of a next-hop IP from the op_lut process state machine, returning MAC and hit/miss.

Parameters:
- ARP_LUT_DEPTH_BITS, 4, log2 of entry count; DEPTH = 2**ARP_LUT_DEPTH_BITS.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- lookup_req  in  1  single-cycle pulse, start lookup of lookup_ip
- lookup_ip  in  32  next-hop IP to resolve
- lookup_done  out  1  single-cycle pulse, result valid
- lookup_hit  out  1  1 = entry found; held until next lookup_done
- lookup_mac  out  48  MAC of matching entry; 0 on miss; held until next lookup_done
- lookup_busy  out  1  high while a scan is in progress
- arp_rd_addr  in  ARP_LUT_DEPTH_BITS  register read index
- arp_rd_req  in  1  level; held by requester until ack
- arp_rd_mac  out  48  entry MAC at arp_rd_addr
- arp_rd_ip  out  32  entry IP at arp_rd_addr
- arp_rd_ack  out  1  one-cycle pulse
- arp_wr_addr  in  ARP_LUT_DEPTH_BITS  register write index
- arp_wr_req  in  1  level; held until ack
- arp_wr_mac  in  48  MAC to write
- arp_wr_ip  in  32  IP to write
- arp_wr_ack  out  1  one-cycle pulse

Behaviour:
- Reset (reset = 0, asynchronous): all entries IP = 0, MAC = 0; all outputs 0; FSM in IDLE.
- Entry validity: an entry with IP == 0 is invalid and never matches. Lookup of IP 0 therefore always misses.
- Write:
  - Performed on the rising edge where arp_wr_req & ~arp_wr_ack.
  - arp_wr_ack is registered as arp_wr_req & ~arp_wr_ack.
  - Result: one ack per request; ack appears 1 cycle after req is sampled; one write per request.
- Read:
  - arp_rd_ack is registered as arp_rd_req & ~arp_rd_ack.
  - arp_rd_mac/arp_rd_ip are registered in the same cycle and held until the next read.
  - Read and write to the same index in the same cycle: read returns the pre-write contents.
- Lookup FSM states: IDLE, SEARCH, DONE.
  - IDLE: lookup_req = 1 latches lookup_ip, sets index = 0, goes to SEARCH, lookup_busy = 1.
  - SEARCH, one entry compared per cycle:
    - Match (entry valid and IP equal): latch MAC, hit = 1, go to DONE.
    - Otherwise, if index == DEPTH-1 (wrap point): hit = 0, MAC = 0, go to DONE.
    - Otherwise index++.
  - DONE: lookup_done = 1 for one cycle, lookup_busy = 0, go to IDLE.
- Latency: lookup_req sampled at edge T.
  - First match at index i: lookup_done high in cycle T+2+i.
  - Miss: lookup_done high in cycle T+1+DEPTH.
- Lowest index wins when duplicate IPs exist.
- lookup_req while busy (SEARCH/DONE) is ignored; no queueing. The requester must wait for lookup_done.
- Write during a scan takes effect immediately.
  - Entries not yet compared see new contents.
  - Already-compared entries are not rescanned.
  - Register writes are never stalled by lookups.
- lookup_hit/lookup_mac change only on the DONE transition.

Optional Feature:
- Macro: ARP_LUT_LAST_HIT_CACHE_EN
- Defined:
  - Adds a one-entry cache (IP, MAC, valid) loaded on every hit.
  - In IDLE, if lookup_req with lookup_ip == cached IP and valid: skip SEARCH, go directly to DONE with hit = 1 and the cached MAC. lookup_done is then high in cycle T+1.
  - Any accepted register write clears cache valid in the same edge.
  - Reset clears the cache.
- Undefined: no cache; every lookup scans with the latency above.

Test Plan:
- Reset then read index 5 -> arp_rd_ack pulses once 1 cycle after req; arp_rd_ip = 0, arp_rd_mac = 0.
- Write index 3 = (0x0A000001, 0x001122334455), then lookup 0x0A000001 -> lookup_done at T+5, hit = 1, mac = 0x001122334455. With cache enabled, a repeat lookup -> done at T+1.
- Lookup 0xC0A80001 on an empty table -> done at T+17 (DEPTH = 16), hit = 0, mac = 0. Also lookup 0x00000000 -> miss.
- Same IP 0x0A000002 at indices 9 and 2 with MACs 0x...09 and 0x...02 -> hit returns 0x...02, done at T+4.
- Start a lookup of 0x0A000007 on an empty table; write it to index 12 at T+3 -> hit at T+14. A write to index 0 at T+3 with the same IP -> miss. With cache enabled, any write clears cache valid.
- arp_wr_req held high 4 cycles -> exactly two acks, 2 cycles apart, each performing one write. Assert reset mid-scan -> lookup_busy = 0 and table cleared immediately; no lookup_done pulse.

Source files
------------

// File: rtl/router_op_lut_arp_table_if.sv
// Lookup and register-access port between the op_lut block (master) and its
// next-hop ARP table (slave).
interface router_op_lut_arp_table_if #(
    parameter int ARP_LUT_DEPTH_BITS = 4
);
    logic                          lookup_req;
    logic [31:0]                   lookup_ip;
    logic                          lookup_done;
    logic                          lookup_hit;
    logic [47:0]                   lookup_mac;
    logic                          lookup_busy;

    logic [ARP_LUT_DEPTH_BITS-1:0] arp_rd_addr;
    logic                          arp_rd_req;
    logic [47:0]                   arp_rd_mac;
    logic [31:0]                   arp_rd_ip;
    logic                          arp_rd_ack;

    logic [ARP_LUT_DEPTH_BITS-1:0] arp_wr_addr;
    logic                          arp_wr_req;
    logic [47:0]                   arp_wr_mac;
    logic [31:0]                   arp_wr_ip;
    logic                          arp_wr_ack;

    modport master (
        output lookup_req, lookup_ip,
        input  lookup_done, lookup_hit, lookup_mac, lookup_busy,
        output arp_rd_addr, arp_rd_req,
        input  arp_rd_mac, arp_rd_ip, arp_rd_ack,
        output arp_wr_addr, arp_wr_req, arp_wr_mac, arp_wr_ip,
        input  arp_wr_ack
    );

    modport slave (
        input  lookup_req, lookup_ip,
        output lookup_done, lookup_hit, lookup_mac, lookup_busy,
        input  arp_rd_addr, arp_rd_req,
        output arp_rd_mac, arp_rd_ip, arp_rd_ack,
        input  arp_wr_addr, arp_wr_req, arp_wr_mac, arp_wr_ip,
        output arp_wr_ack
    );
endinterface

// File: rtl/router_op_lut_arp_table.sv
// Flop-based next-hop ARP table: register read/write port plus a one-entry-per-cycle
// scanning IP->MAC lookup. Define ARP_LUT_LAST_HIT_CACHE_EN to add a last-hit cache.
module router_op_lut_arp_table #(
    parameter int ARP_LUT_DEPTH_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    router_op_lut_arp_table_if.slave bus
);
    localparam int DEPTH = 2 ** ARP_LUT_DEPTH_BITS;
    localparam logic [ARP_LUT_DEPTH_BITS-1:0] LAST_IDX = {ARP_LUT_DEPTH_BITS{1'b1}};

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

    logic [31:0]                   entry_ip_q  [DEPTH];
    logic [47:0]                   entry_mac_q [DEPTH];
    logic                          wr_ack_q, rd_ack_q;
    logic [31:0]                   rd_ip_q;
    logic [47:0]                   rd_mac_q;

    state_e                        state_q;
    logic [ARP_LUT_DEPTH_BITS-1:0] idx_q;
    logic [31:0]                   key_q;
    logic                          busy_q, done_q, hit_q;
    logic [47:0]                   res_mac_q;

    logic                          wr_fire, rd_fire;
    logic [31:0]                   scan_ip;
    logic [47:0]                   scan_mac;
    logic                          scan_match;
    logic                          cache_hit;
    logic [47:0]                   cache_mac;

    // The ack feeds back into the fire term so a held request is served once per ack.
    assign wr_fire = bus.arp_wr_req & ~wr_ack_q;
    assign rd_fire = bus.arp_rd_req & ~rd_ack_q;

    // IP 0 marks an empty slot, so it can never produce a hit.
    assign scan_ip    = entry_ip_q[idx_q];
    assign scan_mac   = entry_mac_q[idx_q];
    assign scan_match = (scan_ip != 32'd0) && (scan_ip == key_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the table itself is reset because an all-zero table is the defined empty state.
            for (int i = 0; i < DEPTH; i++) begin
                entry_ip_q[i]  <= '0;
                entry_mac_q[i] <= '0;
            end
            wr_ack_q <= 1'b0;
            rd_ack_q <= 1'b0;
            rd_ip_q  <= '0;
            rd_mac_q <= '0;
        end else begin
            // NOTE: non-blocking updates make a same-cycle read return the pre-write entry.
            wr_ack_q <= wr_fire;
            rd_ack_q <= rd_fire;
            if (wr_fire) begin
                entry_ip_q[bus.arp_wr_addr]  <= bus.arp_wr_ip;
                entry_mac_q[bus.arp_wr_addr] <= bus.arp_wr_mac;
            end
            if (rd_fire) begin
                rd_ip_q  <= entry_ip_q[bus.arp_rd_addr];
                rd_mac_q <= entry_mac_q[bus.arp_rd_addr];
            end
        end
    end

`ifdef ARP_LUT_LAST_HIT_CACHE_EN
    logic        cache_valid_q;
    logic [31:0] cache_ip_q;
    logic [47:0] cache_mac_q;

    assign cache_hit = cache_valid_q && (bus.lookup_ip == cache_ip_q);
    assign cache_mac = cache_mac_q;

    // Any table write may stale the cached pair, so it wins over a same-edge reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cache_valid_q <= 1'b0;
            cache_ip_q    <= '0;
            cache_mac_q   <= '0;
        end else if (wr_fire) begin
            cache_valid_q <= 1'b0;
        end else if (state_q == SEARCH && scan_match) begin
            cache_valid_q <= 1'b1;
            cache_ip_q    <= key_q;
            cache_mac_q   <= scan_mac;
        end
    end
`else
    assign cache_hit = 1'b0;
    assign cache_mac = '0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            key_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            res_mac_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.lookup_req && cache_hit) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        hit_q     <= 1'b1;
                        res_mac_q <= cache_mac;
                    end else if (bus.lookup_req) begin
                        state_q <= SEARCH;
                        key_q   <= bus.lookup_ip;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (scan_match) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        hit_q     <= 1'b1;
                        res_mac_q <= scan_mac;
                    end else if (idx_q == LAST_IDX) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        hit_q     <= 1'b0;
                        res_mac_q <= '0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.lookup_done = done_q;
    assign bus.lookup_hit  = hit_q;
    assign bus.lookup_mac  = res_mac_q;
    assign bus.lookup_busy = busy_q;
    assign bus.arp_rd_ack  = rd_ack_q;
    assign bus.arp_rd_ip   = rd_ip_q;
    assign bus.arp_rd_mac  = rd_mac_q;
    assign bus.arp_wr_ack  = wr_ack_q;
endmodule

// File: tb/tb_router_op_lut_arp_table.sv
// Scoreboard bench for router_op_lut_arp_table: directed corner cases then random traffic,
// predicted by a first-match table model (honours ARP_LUT_LAST_HIT_CACHE_EN when defined).
module tb_router_op_lut_arp_table;
    localparam int DB    = 4;
    localparam int DEPTH = 1 << DB;

    typedef struct {
        logic        hit;
        logic [47:0] mac;
        int          cyc;
    } lk_exp_t;

    typedef struct {
        logic [31:0] ip;
        logic [47:0] mac;
    } rd_exp_t;

    logic    clk    = 1'b0;
    logic    reset  = 1'b0;
    int      cyc    = 0;
    int      checks = 0;
    int      errors = 0;
    lk_exp_t lk_q[$];
    rd_exp_t rd_q[$];
    lk_exp_t mon_lk;
    rd_exp_t mon_rd;

    logic [31:0] m_ip  [DEPTH];
    logic [47:0] m_mac [DEPTH];
`ifdef ARP_LUT_LAST_HIT_CACHE_EN
    logic        c_valid;
    logic [31:0] c_ip;
    logic [47:0] c_mac;
`endif

    router_op_lut_arp_table_if #(.ARP_LUT_DEPTH_BITS(DB)) bus ();
    router_op_lut_arp_table #(.ARP_LUT_DEPTH_BITS(DB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    // cyc equals the number of rising edges seen; the period after edge k is cycle k+1.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_ip[i]  = '0;
            m_mac[i] = '0;
        end
`ifdef ARP_LUT_LAST_HIT_CACHE_EN
        c_valid = 1'b0;
`endif
    endtask

    task automatic model_write(input int addr, input logic [31:0] ip, input logic [47:0] mac);
        m_ip[addr]  = ip;
        m_mac[addr] = mac;
`ifdef ARP_LUT_LAST_HIT_CACHE_EN
        c_valid = 1'b0;
`endif
    endtask

    // Result of resolving ip when the request is sampled on edge t.
    function automatic lk_exp_t predict(input logic [31:0] ip, input int t);
        lk_exp_t e;
        e.hit = 1'b0;
        e.mac = '0;
        e.cyc = t + 1 + DEPTH;
`ifdef ARP_LUT_LAST_HIT_CACHE_EN
        if (c_valid && c_ip == ip) begin
            e.hit = 1'b1;
            e.mac = c_mac;
            e.cyc = t + 1;
            return e;
        end
`endif
        // Walk from the top so the lowest matching index is the one kept.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (ip != 32'd0 && m_ip[i] == ip) begin
                e.hit = 1'b1;
                e.mac = m_mac[i];
                e.cyc = t + 2 + i;
            end
        end
        return e;
    endfunction

    // All driver tasks start and end on a falling edge.
    task automatic issue_lookup_raw(input logic [31:0] ip);
        bus.lookup_req = 1'b1;
        bus.lookup_ip  = ip;
        @(negedge clk);
        bus.lookup_req = 1'b0;
    endtask

    task automatic issue_lookup(input logic [31:0] ip);
        lk_exp_t e;
        e = predict(ip, cyc + 1);
        lk_q.push_back(e);
`ifdef ARP_LUT_LAST_HIT_CACHE_EN
        if (e.hit) begin
            c_valid = 1'b1;
            c_ip    = ip;
            c_mac   = e.mac;
        end
`endif
        issue_lookup_raw(ip);
    endtask

    task automatic wait_done();
        int waited = 0;
        while (!bus.lookup_done && waited < DEPTH + 4) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.lookup_done) check("lookup_done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    task automatic do_lookup(input logic [31:0] ip);
        issue_lookup(ip);
        wait_done();
    endtask

    task automatic do_write(input int addr, input logic [31:0] ip, input logic [47:0] mac);
        bus.arp_wr_req  = 1'b1;
        bus.arp_wr_addr = DB'(addr);
        bus.arp_wr_ip   = ip;
        bus.arp_wr_mac  = mac;
        model_write(addr, ip, mac);
        @(negedge clk);
        check("wr_ack_rise", 64'(bus.arp_wr_ack), 64'd1);
        bus.arp_wr_req = 1'b0;
        @(negedge clk);
        check("wr_ack_fall", 64'(bus.arp_wr_ack), 64'd0);
    endtask

    task automatic do_read(input int addr);
        rd_exp_t r;
        r.ip  = m_ip[addr];
        r.mac = m_mac[addr];
        rd_q.push_back(r);
        bus.arp_rd_req  = 1'b1;
        bus.arp_rd_addr = DB'(addr);
        @(negedge clk);
        check("rd_ack_rise", 64'(bus.arp_rd_ack), 64'd1);
        bus.arp_rd_req = 1'b0;
        @(negedge clk);
        check("rd_ack_fall", 64'(bus.arp_rd_ack), 64'd0);
    endtask

    // Monitor: pops a prediction whenever the DUT presents a result.
    always @(negedge clk) begin
        if (bus.lookup_done) begin
            if (lk_q.size() == 0) begin
                check("lookup_done_unexpected", 64'd1, 64'd0);
            end else begin
                mon_lk = lk_q.pop_front();
                check("lookup_hit", 64'(bus.lookup_hit), 64'(mon_lk.hit));
                check("lookup_mac", 64'(bus.lookup_mac), 64'(mon_lk.mac));
                check("lookup_done_cycle", 64'(cyc + 1), 64'(mon_lk.cyc));
            end
        end
        if (bus.arp_rd_ack) begin
            if (rd_q.size() == 0) begin
                check("rd_ack_unexpected", 64'd1, 64'd0);
            end else begin
                mon_rd = rd_q.pop_front();
                check("rd_ip", 64'(bus.arp_rd_ip), 64'(mon_rd.ip));
                check("rd_mac", 64'(bus.arp_rd_mac), 64'(mon_rd.mac));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        checks++;
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [31:0] ip;
        logic [47:0] mac;
        lk_exp_t     e;
        int          t0;

        bus.lookup_req  = 1'b0;
        bus.lookup_ip   = '0;
        bus.arp_rd_req  = 1'b0;
        bus.arp_rd_addr = '0;
        bus.arp_wr_req  = 1'b0;
        bus.arp_wr_addr = '0;
        bus.arp_wr_ip   = '0;
        bus.arp_wr_mac  = '0;
        model_clear();

        repeat (2) @(negedge clk);
        check("rst_lookup_done", 64'(bus.lookup_done), 64'd0);
        check("rst_lookup_hit",  64'(bus.lookup_hit),  64'd0);
        check("rst_lookup_mac",  64'(bus.lookup_mac),  64'd0);
        check("rst_lookup_busy", 64'(bus.lookup_busy), 64'd0);
        check("rst_rd_ack",      64'(bus.arp_rd_ack),  64'd0);
        check("rst_wr_ack",      64'(bus.arp_wr_ack),  64'd0);
        check("rst_rd_ip",       64'(bus.arp_rd_ip),   64'd0);
        check("rst_rd_mac",      64'(bus.arp_rd_mac),  64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Empty table: register read, full-length misses, IP 0 never matches.
        do_read(5);
        do_lookup(32'hC0A8_0001);
        do_lookup(32'h0000_0000);

        // Single entry at index 3, then a repeat lookup of the same IP.
        do_write(3, 32'h0A00_0001, 48'h0011_2233_4455);
        do_lookup(32'h0A00_0001);
        do_lookup(32'h0A00_0001);

        // Duplicate IPs: lowest index wins.
        do_write(9, 32'h0A00_0002, 48'h0000_0000_0009);
        do_write(2, 32'h0A00_0002, 48'h0000_0000_0002);
        do_lookup(32'h0A00_0002);

        // A request raised mid-scan is ignored and the latched key is kept.
        issue_lookup(32'h0A00_0001);
        @(negedge clk);
        bus.lookup_req = 1'b1;
        bus.lookup_ip  = 32'h0A00_0002;
        repeat (2) @(negedge clk);
        bus.lookup_req = 1'b0;
        bus.lookup_ip  = '0;
        wait_done();

        // Same-cycle read and write of one index: read sees the old entry.
        do_write(7, 32'h0A00_0003, 48'hAAAA_0000_0007);
        begin
            rd_exp_t r;
            r.ip  = m_ip[7];
            r.mac = m_mac[7];
            rd_q.push_back(r);
        end
        bus.arp_rd_req  = 1'b1;
        bus.arp_rd_addr = DB'(7);
        bus.arp_wr_req  = 1'b1;
        bus.arp_wr_addr = DB'(7);
        bus.arp_wr_ip   = 32'h0A00_0004;
        bus.arp_wr_mac  = 48'hBBBB_0000_0007;
        model_write(7, 32'h0A00_0004, 48'hBBBB_0000_0007);
        @(negedge clk);
        check("rw_wr_ack", 64'(bus.arp_wr_ack), 64'd1);
        bus.arp_rd_req = 1'b0;
        bus.arp_wr_req = 1'b0;
        @(negedge clk);
        do_read(7);

        // Write request held for four cycles: acks on the 1st and 3rd cycle, two writes.
        bus.arp_wr_req  = 1'b1;
        bus.arp_wr_addr = DB'(5);
        bus.arp_wr_ip   = 32'h0A00_0005;
        bus.arp_wr_mac  = 48'h0000_5555_0005;
        model_write(5, 32'h0A00_0005, 48'h0000_5555_0005);
        @(negedge clk);
        check("held_ack_1", 64'(bus.arp_wr_ack), 64'd1);
        bus.arp_wr_addr = DB'(6);
        bus.arp_wr_ip   = 32'h0A00_0006;
        bus.arp_wr_mac  = 48'h0000_6666_0006;
        model_write(6, 32'h0A00_0006, 48'h0000_6666_0006);
        @(negedge clk);
        check("held_ack_2", 64'(bus.arp_wr_ack), 64'd0);
        @(negedge clk);
        check("held_ack_3", 64'(bus.arp_wr_ack), 64'd1);
        @(negedge clk);
        check("held_ack_4", 64'(bus.arp_wr_ack), 64'd0);
        bus.arp_wr_req = 1'b0;
        @(negedge clk);
        do_read(5);
        do_read(6);

        // Write landing ahead of the scan pointer is seen: hit at index 12, done at T+14.
        t0 = cyc + 1;
        e.hit = 1'b1;
        e.mac = 48'h0000_7777_000C;
        e.cyc = t0 + 14;
        lk_q.push_back(e);
        issue_lookup_raw(32'h0A00_0007);
        repeat (2) @(negedge clk);
        do_write(12, 32'h0A00_0007, 48'h0000_7777_000C);
`ifdef ARP_LUT_LAST_HIT_CACHE_EN
        c_valid = 1'b1;
        c_ip    = 32'h0A00_0007;
        c_mac   = 48'h0000_7777_000C;
`endif
        wait_done();

        // Write landing behind the scan pointer is not rescanned: miss.
        do_write(12, 32'h0, 48'h0);
        t0 = cyc + 1;
        e.hit = 1'b0;
        e.mac = '0;
        e.cyc = t0 + 1 + DEPTH;
        lk_q.push_back(e);
        issue_lookup_raw(32'h0A00_0007);
        repeat (2) @(negedge clk);
        do_write(0, 32'h0A00_0007, 48'h0000_7777_0000);
        wait_done();

        // Hit, repeat (cache candidate), then an unrelated write invalidates any cache.
        do_lookup(32'h0A00_0007);
        do_lookup(32'h0A00_0007);
        do_write(15, 32'h0A00_0008, 48'h0000_8888_000F);
        do_lookup(32'h0A00_0007);

        // Random traffic against the model.
        for (int n = 0; n < 60; n++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if ($urandom_range(0, 4) == 0) ip = 32'h0;
            else ip = 32'h0A00_0000 | 32'($urandom_range(1, 7));
            mac = {16'($urandom), $urandom};
            if (op < 4)      do_write(int'($urandom_range(0, DEPTH - 1)), ip, mac);
            else if (op < 8) do_lookup(ip);
            else             do_read(int'($urandom_range(0, DEPTH - 1)));
        end

        // Reset in the middle of a scan: busy drops at once, no done pulse, table cleared.
        do_write(4, 32'h0A00_0009, 48'h0000_9999_0004);
        issue_lookup_raw(32'hDEAD_BEEF);
        repeat (4) @(negedge clk);
        check("busy_mid_scan", 64'(bus.lookup_busy), 64'd1);
        reset = 1'b0;
        #1;
        check("busy_after_rst",  64'(bus.lookup_busy), 64'd0);
        check("done_after_rst",  64'(bus.lookup_done), 64'd0);
        check("hit_after_rst",   64'(bus.lookup_hit),  64'd0);
        check("mac_after_rst",   64'(bus.lookup_mac),  64'd0);
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        do_read(4);
        do_read(3);
        do_lookup(32'h0A00_0009);

        repeat (3) @(negedge clk);
        check("lookup_queue_drained", 64'(lk_q.size()), 64'd0);
        check("read_queue_drained",   64'(rd_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
